// File: rtl/sdram_frame_writer.sv
// Frame writer: turns the captured RGB565 pixel stream into FIFO pushes plus
// SDRAM burst requests, one frame per ping-pong bank.
module sdram_frame_writer #(
    parameter int unsigned H_PIXELS   = 640,
    parameter int unsigned V_LINES    = 480,
    parameter int unsigned BURST_LEN  = 256,
    parameter int unsigned FIFO_DEPTH = 512,
    parameter int unsigned ADDR_W     = 22
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_load,
    input  logic [1:0]        wr_bank,
    input  logic              pix_vsync,
    input  logic              pix_valid,
    input  logic [15:0]       pix_data,
    output logic              fifo_wr_en,
    output logic [15:0]       fifo_wr_data,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [8:0]        wr_len,
    input  logic              wr_ack,
    output logic              bank_valid,
    output logic              frame_write_done,
    output logic              overflow,
    output logic              short_frame
);

    localparam int unsigned FRAME_WORDS = H_PIXELS * V_LINES;
    localparam int unsigned CNT_W       = $clog2(FRAME_WORDS + 1);
    localparam int unsigned PEND_W      = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OFF_W       = ADDR_W - 2;

    localparam logic [CNT_W-1:0]  FRAME_CNT  = CNT_W'(FRAME_WORDS);
    localparam logic [PEND_W-1:0] FIFO_FULL  = PEND_W'(FIFO_DEPTH);
    localparam logic [PEND_W-1:0] BURST_PEND = PEND_W'(BURST_LEN);
    localparam logic [8:0]        BURST_W    = 9'(BURST_LEN);

    typedef enum logic [2:0] {
        StIdle,
        StWaitVs,
        StCapture,
        StFlush,
        StDone,
        StAbort
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         vsync_q;  // [0] newer, [1] older
    logic [1:0]         bank_q, bank_d;
    logic [OFF_W-1:0]   offset_q, offset_d;
    logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [PEND_W-1:0]  pending_q, pending_d;
    logic               wr_req_q, wr_req_d;
    logic [8:0]         wr_len_q, wr_len_d;
    logic               bank_valid_q, bank_valid_d;
    logic               done_q, done_d;
    logic               overflow_q, overflow_d;
    logic               short_q, short_d;
    logic               fifo_wr_en_q;
    logic [15:0]        fifo_wr_data_q;

    logic vs_fall, vs_rise, pix_strobe, in_frame, frame_room, fifo_room, push, ack;

    assign vs_fall    = vsync_q[1] & ~vsync_q[0];
    assign vs_rise    = ~vsync_q[1] & vsync_q[0];
    assign pix_strobe = pix_valid & ~pix_vsync;
    assign in_frame   = (state_q == StCapture);
    assign frame_room = (pix_cnt_q < FRAME_CNT);
    assign fifo_room  = (pending_q < FIFO_FULL);
    assign push       = in_frame & pix_strobe & frame_room & fifo_room;
    assign ack        = wr_req_q & wr_ack;

    // Next-state: word accounting, burst issue and frame sequencing
    always_comb begin
        state_d      = state_q;
        bank_d       = bank_q;
        offset_d     = offset_q;
        pix_cnt_d    = pix_cnt_q;
        wr_req_d     = wr_req_q;
        wr_len_d     = wr_len_q;
        bank_valid_d = bank_valid_q;
        done_d       = done_q;
        overflow_d   = overflow_q;
        short_d      = short_q;

        pending_d = pending_q + PEND_W'(push) - (ack ? PEND_W'(wr_len_q) : '0);
        if (push) begin
            pix_cnt_d = pix_cnt_q + 1'b1;
        end
        if (in_frame && pix_strobe && frame_room && !fifo_room) begin
            overflow_d = 1'b1;
        end

        // Offset advances modulo the per-bank space; the cast drops any carry.
        if (ack) begin
            wr_req_d = 1'b0;
            offset_d = offset_q + OFF_W'(wr_len_q);
        end

        // A new request is only raised from a low wr_req, so wr_req always
        // shows at least one low cycle between bursts.
        if (!wr_req_q) begin
            if (state_q == StCapture && pending_q >= BURST_PEND) begin
                wr_req_d = 1'b1;
                wr_len_d = BURST_W;
            end else if ((state_q == StFlush || state_q == StAbort) && pending_q != '0) begin
                wr_req_d = 1'b1;
                wr_len_d = (pending_q >= BURST_PEND) ? BURST_W : 9'(pending_q);
            end
        end

        unique case (state_q)
            StIdle: begin
                if (wr_load) begin
                    offset_d = '0;
                    state_d  = StWaitVs;
                end
            end
            StWaitVs: begin
                if (vs_fall) begin
                    bank_d       = wr_bank;
                    pix_cnt_d    = '0;
                    bank_valid_d = 1'b1;
                    done_d       = 1'b0;
                    state_d      = StCapture;
                end
            end
            StCapture: begin
                if (vs_rise || pix_cnt_q == FRAME_CNT) begin
                    bank_valid_d = 1'b0;
                    state_d      = StFlush;
                    if (pix_cnt_q != FRAME_CNT) begin
                        short_d = 1'b1;
                    end
                end
            end
            StFlush: begin
                if (pending_q == '0 && !wr_req_q) begin
                    done_d  = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            StAbort: begin
                // Words already pushed are drained to memory; the offset is
                // cleared only once the last ack has landed so it cannot be
                // bumped again afterwards.
                if (pending_q == '0 && !wr_req_q) begin
                    offset_d = '0;
                    done_d   = 1'b1;
                    state_d  = StWaitVs;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (wr_load && state_q != StIdle) begin
            bank_valid_d = 1'b0;
            state_d      = StAbort;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            vsync_q        <= 2'b00;
            bank_q         <= 2'b00;
            offset_q       <= '0;
            pix_cnt_q      <= '0;
            pending_q      <= '0;
            wr_req_q       <= 1'b0;
            wr_len_q       <= '0;
            bank_valid_q   <= 1'b0;
            done_q         <= 1'b1;
            overflow_q     <= 1'b0;
            short_q        <= 1'b0;
            fifo_wr_en_q   <= 1'b0;
            fifo_wr_data_q <= '0;
        end else begin
            state_q        <= state_d;
            vsync_q        <= {vsync_q[0], pix_vsync};
            bank_q         <= bank_d;
            offset_q       <= offset_d;
            pix_cnt_q      <= pix_cnt_d;
            pending_q      <= pending_d;
            wr_req_q       <= wr_req_d;
            wr_len_q       <= wr_len_d;
            bank_valid_q   <= bank_valid_d;
            done_q         <= done_d;
            overflow_q     <= overflow_d;
            short_q        <= short_d;
            fifo_wr_en_q   <= push;
            if (push) begin
                fifo_wr_data_q <= pix_data;
            end
        end
    end

    assign fifo_wr_en       = fifo_wr_en_q;
    assign fifo_wr_data     = fifo_wr_data_q;
    assign wr_req           = wr_req_q;
    assign wr_addr          = {bank_q, offset_q};
    assign wr_len           = wr_len_q;
    assign bank_valid       = bank_valid_q;
    assign frame_write_done = done_q;
    assign overflow         = overflow_q;
    assign short_frame      = short_q;

endmodule
